// File: rtl/light_stand_pkg.sv
// rtl/light_stand_pkg.sv - brightness state type and FSM step function for the light stand
package light_stand_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_HIGH = 2'd3
    } state_t;

    function automatic state_t next_state(input state_t s);
        case (s)
            ST_OFF:  return ST_LOW;
            ST_LOW:  return ST_MID;
            ST_MID:  return ST_HIGH;
            default: return ST_OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - tick-sampled button debouncer with registered rising-level pulse
module btn_debouncer #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_btn_sync,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt     <= '0;
            o_level <= 1'b0;
            level_d <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            level_d <= o_level;
            o_rise  <= o_level & ~level_d;
            if (i_tick) begin
                if (i_btn_sync == o_level) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                    // this differing sample is the DEBOUNCE_TICKS-th in a row
                    o_level <= ~o_level;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/light_stand_ctrl.sv
// rtl/light_stand_ctrl.sv - light stand brightness sequencer with PWM LED drive; optional LIGHT_STAND_AUTO_OFF_EN auto-off timer
module light_stand_ctrl
    import light_stand_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int PWM_W          = 8,
    parameter int DUTY_LOW       = 64,
    parameter int DUTY_MID       = 160
`ifdef LIGHT_STAND_AUTO_OFF_EN
    ,
    parameter int AUTO_OFF_TICKS = 1000
`endif
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_div_clk,
    input  logic       i_btn,
    output logic       o_led,
    output logic [1:0] o_state,
    output logic       o_press
);

    localparam int PW1 = PWM_W + 1;
    localparam logic [PWM_W:0] DUTY_L = PW1'(DUTY_LOW);
    localparam logic [PWM_W:0] DUTY_M = PW1'(DUTY_MID);
    localparam logic [PWM_W:0] DUTY_H = {1'b1, {PWM_W{1'b0}}};

    logic             div_s1, div_s2, div_s3, tick;
    logic             btn_s1, btn_s2;
    logic             unused_level;
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W:0]   duty;
    state_t           state;

    // i_div_clk is only ever sampled as data; tick is a registered rising edge
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_s1 <= 1'b0;
            div_s2 <= 1'b0;
            div_s3 <= 1'b0;
            tick   <= 1'b0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            div_s1 <= i_div_clk;
            div_s2 <= div_s1;
            div_s3 <= div_s2;
            tick   <= div_s2 & ~div_s3;
            btn_s1 <= i_btn;
            btn_s2 <= btn_s1;
        end
    end

    btn_debouncer #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debouncer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_tick    (tick),
        .i_btn_sync(btn_s2),
        .o_level   (unused_level),
        .o_rise    (o_press)
    );

`ifdef LIGHT_STAND_AUTO_OFF_EN
    localparam int TW = $clog2(AUTO_OFF_TICKS + 1);
    logic [TW-1:0] timer;

    // a press in the expiry cycle wins over the timeout
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_OFF;
            timer <= '0;
        end else if (o_press) begin
            state <= next_state(state);
            timer <= '0;
        end else if (state == ST_OFF) begin
            timer <= '0;
        end else if (tick) begin
            if (timer == TW'(AUTO_OFF_TICKS - 1)) begin
                state <= ST_OFF;
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_OFF;
        end else if (o_press) begin
            state <= next_state(state);
        end
    end
`endif

    always_comb begin
        duty = '0;
        case (state)
            ST_OFF:  duty = '0;
            ST_LOW:  duty = DUTY_L;
            ST_MID:  duty = DUTY_M;
            default: duty = DUTY_H;
        endcase
    end

    // one extra compare bit lets HIGH (2**PWM_W) hold the LED on permanently
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_cnt <= '0;
            o_led   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            o_led   <= ({1'b0, pwm_cnt} < duty);
        end
    end

    assign o_state = state;

endmodule
